// File: rtl/bsg_manycore_cache_link_responder.sv
// rtl/bsg_manycore_cache_link_responder.sv - single-outstanding load/store responder for one cache link
module bsg_manycore_cache_link_responder #(
  parameter int addr_width_p     = 28,
  parameter int data_width_p     = 32,
  parameter int x_cord_width_p   = 4,
  parameter int y_cord_width_p   = 4,
  parameter int load_id_width_p  = 12,
  parameter int mem_addr_width_p = 20,
  parameter logic [data_width_p-1:0] oor_data_p = 32'hDEAD_BEEF
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         req_v_i,
  input  logic                         req_w_i,
  input  logic [addr_width_p-1:0]      req_addr_i,
  input  logic [data_width_p-1:0]      req_data_i,
  input  logic [data_width_p/8-1:0]    req_mask_i,
  input  logic [x_cord_width_p-1:0]    req_src_x_i,
  input  logic [y_cord_width_p-1:0]    req_src_y_i,
  input  logic [load_id_width_p-1:0]   req_load_id_i,
  output logic                         req_yumi_o,
  output logic                         resp_v_o,
  output logic                         resp_w_o,
  output logic [data_width_p-1:0]      resp_data_o,
  output logic [x_cord_width_p-1:0]    resp_dst_x_o,
  output logic [y_cord_width_p-1:0]    resp_dst_y_o,
  output logic [load_id_width_p-1:0]   resp_load_id_o,
  input  logic                         resp_ready_i,
  output logic                         mem_v_o,
  output logic                         mem_w_o,
  output logic [mem_addr_width_p-1:0]  mem_addr_o,
  output logic [data_width_p-1:0]      mem_data_o,
  output logic [data_width_p/8-1:0]    mem_mask_o,
  input  logic                         mem_ready_i,
  input  logic                         mem_data_v_i,
  input  logic [data_width_p-1:0]      mem_data_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  state_e                        r_state;
  state_e                        w_state_next;
  logic                          w_yumi;
  logic                          w_oor;
  logic                          w_capture_req;
  logic                          w_capture_mem;

  logic                          r_w;
  logic [mem_addr_width_p-1:0]   r_addr;
  logic [data_width_p-1:0]       r_data;
  logic [data_width_p/8-1:0]     r_mask;
  logic [x_cord_width_p-1:0]     r_src_x;
  logic [y_cord_width_p-1:0]     r_src_y;
  logic [load_id_width_p-1:0]    r_load_id;
  logic [data_width_p-1:0]       r_resp_data;

  // Any address bit above the backing memory makes the request out of range.
  assign w_oor = (req_addr_i >> mem_addr_width_p) != '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_yumi        = 1'b0;
    w_capture_req = 1'b0;
    w_capture_mem = 1'b0;
    resp_v_o      = 1'b0;
    mem_v_o       = 1'b0;
    case (r_state)
      IDLE: begin
        w_yumi = req_v_i & reset_n_i;
        if (w_yumi) begin
          w_capture_req = 1'b1;
          w_state_next  = w_oor ? RESP : MEM_REQ;
        end
      end
      MEM_REQ: begin
        mem_v_o = 1'b1;
        if (mem_ready_i) begin
          if (r_w) begin
            w_state_next = RESP;
          end else if (mem_data_v_i) begin
            // Zero-latency memory: read data arrives with the accept.
            w_capture_mem = 1'b1;
            w_state_next  = RESP;
          end else begin
            w_state_next = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_data_v_i) begin
          w_capture_mem = 1'b1;
          w_state_next  = RESP;
        end
      end
      RESP: begin
        resp_v_o = 1'b1;
        if (resp_ready_i) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_w         <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_mask      <= '0;
      r_src_x     <= '0;
      r_src_y     <= '0;
      r_load_id   <= '0;
      r_resp_data <= '0;
    end else if (w_capture_req) begin
      r_w         <= req_w_i;
      r_addr      <= req_addr_i[mem_addr_width_p-1:0];
      r_data      <= req_data_i;
      r_mask      <= req_mask_i;
      r_src_x     <= req_src_x_i;
      r_src_y     <= req_src_y_i;
      r_load_id   <= req_load_id_i;
      // Store acks carry zero; an out-of-range load is answered here and never visits memory.
      r_resp_data <= (w_oor && !req_w_i) ? oor_data_p : '0;
    end else if (w_capture_mem) begin
      r_resp_data <= mem_data_i;
    end
  end

  assign req_yumi_o     = w_yumi;
  assign resp_w_o       = r_w;
  assign resp_data_o    = r_resp_data;
  assign resp_dst_x_o   = r_src_x;
  assign resp_dst_y_o   = r_src_y;
  assign resp_load_id_o = r_load_id;
  assign mem_w_o        = r_w;
  assign mem_addr_o     = r_addr;
  assign mem_data_o     = r_data;
  assign mem_mask_o     = r_mask;

`ifndef SYNTHESIS
  a_no_data_in_idle: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(r_state == IDLE && mem_data_v_i));
`endif

endmodule

// File: tb/tb_bsg_manycore_cache_link_responder.sv
// tb/tb_bsg_manycore_cache_link_responder.sv - randomized scoreboard bench for the cache link responder
module tb_bsg_manycore_cache_link_responder;

  logic        clk_i;
  logic        reset_n_i;
  logic        req_v_i;
  logic        req_w_i;
  logic [27:0] req_addr_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_mask_i;
  logic [3:0]  req_src_x_i;
  logic [3:0]  req_src_y_i;
  logic [11:0] req_load_id_i;
  logic        req_yumi_o;
  logic        resp_v_o;
  logic        resp_w_o;
  logic [31:0] resp_data_o;
  logic [3:0]  resp_dst_x_o;
  logic [3:0]  resp_dst_y_o;
  logic [11:0] resp_load_id_o;
  logic        resp_ready_i;
  logic        mem_v_o;
  logic        mem_w_o;
  logic [19:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [3:0]  mem_mask_o;
  logic        mem_ready_i;
  logic        mem_data_v_i;
  logic [31:0] mem_data_i;

  bsg_manycore_cache_link_responder #(
    .addr_width_p(28), .data_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
    .load_id_width_p(12), .mem_addr_width_p(20), .oor_data_p(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .req_v_i(req_v_i), .req_w_i(req_w_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .req_mask_i(req_mask_i), .req_src_x_i(req_src_x_i), .req_src_y_i(req_src_y_i),
    .req_load_id_i(req_load_id_i), .req_yumi_o(req_yumi_o),
    .resp_v_o(resp_v_o), .resp_w_o(resp_w_o), .resp_data_o(resp_data_o),
    .resp_dst_x_o(resp_dst_x_o), .resp_dst_y_o(resp_dst_y_o), .resp_load_id_o(resp_load_id_o),
    .resp_ready_i(resp_ready_i),
    .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_mask_o(mem_mask_o), .mem_ready_i(mem_ready_i), .mem_data_v_i(mem_data_v_i),
    .mem_data_i(mem_data_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int yumi_cnt = 0;
  int resp_cnt = 0;
  int memv_cnt = 0;
  int wr_cnt = 0;
  int mem_unstable = 0;
  bit mem_auto = 1'b1;
  bit ready_rand = 1'b0;
  bit inject_dv = 1'b0;
  int mem_lat = 0;
  int stall_cnt = 0;
  int last_yumi_cyc, last_hs_cyc;
  logic [31:0] last_resp_data;
  logic [19:0] last_wr_addr;
  logic [31:0] last_wr_data;
  logic [3:0]  last_wr_mask;
  logic [31:0] tb_mem [int];
  logic [31:0] ref_mem [int];
  logic        nb_w;
  logic [27:0] nb_addr;
  logic [31:0] nb_data;
  logic [3:0]  nb_mask;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    #2;
    if (req_yumi_o) yumi_cnt++;
    if (resp_v_o && resp_ready_i) resp_cnt++;
  end

  // Backing memory: configurable accept stalls and read latency.
  initial begin : mem_model
    int pend_cnt;
    logic [19:0] pend_addr;
    logic prev_v, prev_hs;
    logic [56:0] prev_bus, cur_bus;
    logic [31:0] wv;
    pend_cnt = 0; pend_addr = '0; prev_v = 0; prev_hs = 0; prev_bus = '0;
    mem_ready_i = 0; mem_data_v_i = 0; mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_v_o) memv_cnt++;
      if (!mem_auto || !reset_n_i) begin
        pend_cnt = 0;
        prev_v = 0;
        if (mem_auto) begin mem_ready_i = 0; mem_data_v_i = 0; end
      end else begin
        mem_data_v_i = 0;
        if (pend_cnt > 0) begin
          pend_cnt--;
          if (pend_cnt == 0) begin
            mem_data_v_i = 1;
            mem_data_i = tb_mem.exists(int'(pend_addr)) ? tb_mem[int'(pend_addr)] : 32'h0;
          end
        end
        if (stall_cnt > 0 && mem_v_o) begin mem_ready_i = 0; stall_cnt--; end
        else if (pend_cnt > 0) mem_ready_i = 0;
        else mem_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (mem_v_o && mem_ready_i) begin
          if (mem_w_o) begin
            wv = tb_mem.exists(int'(mem_addr_o)) ? tb_mem[int'(mem_addr_o)] : 32'h0;
            for (int b = 0; b < 4; b++) if (mem_mask_o[b]) wv[8*b +: 8] = mem_data_o[8*b +: 8];
            tb_mem[int'(mem_addr_o)] = wv;
            wr_cnt++;
            last_wr_addr = mem_addr_o; last_wr_data = mem_data_o; last_wr_mask = mem_mask_o;
          end else if (mem_lat == 0) begin
            mem_data_v_i = 1;
            mem_data_i = tb_mem.exists(int'(mem_addr_o)) ? tb_mem[int'(mem_addr_o)] : 32'h0;
          end else begin
            pend_cnt = mem_lat; pend_addr = mem_addr_o;
          end
        end
        if (inject_dv && mem_v_o && mem_w_o) begin mem_data_v_i = 1; mem_data_i = 32'hFFFF_FFFF; end
        cur_bus = {mem_w_o, mem_addr_o, mem_data_o, mem_mask_o};
        if (mem_v_o && prev_v && !prev_hs && cur_bus !== prev_bus) mem_unstable++;
        prev_v = mem_v_o; prev_hs = mem_v_o && mem_ready_i; prev_bus = cur_bus;
      end
    end
  end

  // One full request/response exchange, scored against the word-level model.
  task automatic do_txn(input logic w, input logic [27:0] addr, input logic [31:0] data,
                        input logic [3:0] mask, input logic [3:0] x, input logic [3:0] y,
                        input logic [11:0] id, input int hold, input bit keep_req, input int exp_lat);
    logic oor;
    logic [31:0] exp_data, word;
    int memv0, wr0, yc, rc;
    bit got;
    oor = (addr >> 20) != 0;
    word = ref_mem.exists(int'(addr[19:0])) ? ref_mem[int'(addr[19:0])] : 32'h0;
    exp_data = w ? 32'h0 : (oor ? 32'hDEAD_BEEF : word);
    memv0 = memv_cnt; wr0 = wr_cnt; got = 0;
    for (int i = 0; i < 50; i++) begin
      req_w_i = w; req_addr_i = addr; req_data_i = data; req_mask_i = mask;
      req_src_x_i = x; req_src_y_i = y; req_load_id_i = id; req_v_i = 1;
      #1;
      if (req_yumi_o) begin got = 1; break; end
      @(negedge clk_i);
    end
    yc = cyc; last_yumi_cyc = yc;
    checks++;
    if (!got) begin errors++; $display("FAIL yumi_timeout: got no yumi, required yumi within 50 cycles"); end
    @(negedge clk_i);
    req_v_i = 0;
    got = 0;
    for (int i = 0; i < 60; i++) begin
      #1;
      if (resp_v_o) begin got = 1; break; end
      @(negedge clk_i);
    end
    rc = cyc;
    checks++;
    if (!got) begin errors++; $display("FAIL resp_timeout: got no resp_v_o, required within 60 cycles"); end
    if (exp_lat >= 0) begin
      checks++;
      if (rc - yc !== exp_lat) begin
        errors++; $display("FAIL latency: got %0d cycles, required %0d", rc - yc, exp_lat);
      end
    end
    checks++;
    if (resp_w_o !== w) begin errors++; $display("FAIL resp_w: got %b required %b", resp_w_o, w); end
    checks++;
    if (resp_data_o !== exp_data) begin
      errors++; $display("FAIL resp_data: got %h required %h (addr %h)", resp_data_o, exp_data, addr);
    end
    checks++;
    if ({resp_dst_x_o, resp_dst_y_o, resp_load_id_o} !== {x, y, id}) begin
      errors++; $display("FAIL resp_route: got %h required %h", {resp_dst_x_o, resp_dst_y_o, resp_load_id_o}, {x, y, id});
    end
    if (oor) begin
      checks++;
      if (memv_cnt != memv0 || wr_cnt != wr0) begin
        errors++; $display("FAIL oor_mem: got %0d mem_v cycles %0d writes, required 0 and 0", memv_cnt - memv0, wr_cnt - wr0);
      end
    end else if (w) begin
      checks++;
      if (wr_cnt - wr0 != 1) begin errors++; $display("FAIL write_count: got %0d required 1", wr_cnt - wr0); end
      for (int b = 0; b < 4; b++) if (mask[b]) word[8*b +: 8] = data[8*b +: 8];
      ref_mem[int'(addr[19:0])] = word;
    end
    last_resp_data = resp_data_o;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_i);
      if (keep_req) begin
        req_w_i = nb_w; req_addr_i = nb_addr; req_data_i = nb_data; req_mask_i = nb_mask;
        req_src_x_i = x; req_src_y_i = y; req_load_id_i = id; req_v_i = 1;
      end
      #1;
      checks++;
      if ({resp_v_o, resp_w_o, resp_data_o, resp_dst_x_o, resp_dst_y_o, resp_load_id_o} !==
          {1'b1, w, exp_data, x, y, id}) begin
        errors++; $display("FAIL resp_hold: got %h required %h", {resp_v_o, resp_w_o, resp_data_o},
                           {1'b1, w, exp_data});
      end
      if (keep_req) begin
        checks++;
        if (req_yumi_o !== 1'b0) begin errors++; $display("FAIL yumi_busy: got %b required 0", req_yumi_o); end
      end
    end
    @(negedge clk_i);
    resp_ready_i = 1; last_hs_cyc = cyc;
    @(negedge clk_i);
    resp_ready_i = 0;
  endtask

  task automatic test_reset();
    reset_n_i = 0; req_v_i = 0; req_w_i = 0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
    req_src_x_i = '0; req_src_y_i = '0; req_load_id_i = '0; resp_ready_i = 0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if ({req_yumi_o, resp_v_o, mem_v_o, resp_w_o, resp_data_o, resp_dst_x_o, resp_dst_y_o,
         resp_load_id_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: got v=%b%b%b data=%h addr=%h, required all 0",
                         req_yumi_o, resp_v_o, mem_v_o, resp_data_o, mem_addr_o);
    end
    @(negedge clk_i);
    reset_n_i = 1;
    @(negedge clk_i);
  endtask

  task automatic test_load();
    tb_mem[32'h40] = 32'h1234_5678; ref_mem[32'h40] = 32'h1234_5678;
    ready_rand = 0; mem_lat = 3;
    do_txn(0, 28'h40, 32'h0, 4'h0, 4'd2, 4'd1, 12'h05A, 0, 0, -1);
    checks++;
    if (last_resp_data !== 32'h1234_5678) begin
      errors++; $display("FAIL load_0x40: got %h required 12345678", last_resp_data);
    end
    mem_lat = 0;
    do_txn(0, 28'h40, 32'h0, 4'h0, 4'd3, 4'd3, 12'h001, 0, 0, 2);
  endtask

  task automatic test_store();
    ready_rand = 0; mem_lat = 0;
    do_txn(1, 28'h10, 32'hA5A5_A5A5, 4'b0011, 4'd1, 4'd2, 12'h077, 0, 0, 2);
    checks++;
    if ({last_wr_addr, last_wr_mask, last_wr_data} !== {20'h10, 4'b0011, 32'hA5A5_A5A5}) begin
      errors++; $display("FAIL store_bus: got addr %h mask %b data %h required 10 0011 a5a5a5a5",
                         last_wr_addr, last_wr_mask, last_wr_data);
    end
    mem_lat = 2;
    do_txn(0, 28'h10, 32'h0, 4'h0, 4'd1, 4'd2, 12'h078, 0, 0, -1);
    checks++;
    if (last_resp_data !== 32'h0000_A5A5) begin
      errors++; $display("FAIL store_reload: got %h required 0000a5a5", last_resp_data);
    end
  endtask

  task automatic test_oor();
    do_txn(0, 28'h1 << 20, 32'h0, 4'h0, 4'd5, 4'd6, 12'hABC, 0, 0, 1);
    checks++;
    if (last_resp_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL oor_load: got %h required deadbeef", last_resp_data);
    end
    do_txn(1, 28'hFFF_FFFF, 32'h1111_2222, 4'hF, 4'd7, 4'd0, 12'h123, 1, 0, 1);
  endtask

  task automatic test_backpressure();
    int y0;
    mem_lat = 1;
    nb_w = 0; nb_addr = 28'h10; nb_data = 32'h0; nb_mask = 4'h0;
    y0 = yumi_cnt;
    do_txn(1, 28'h11, 32'h5555_AAAA, 4'b1100, 4'd4, 4'd4, 12'h444, 5, 1, -1);
    do_txn(nb_w, nb_addr, nb_data, nb_mask, 4'd4, 4'd4, 12'h444, 0, 0, -1);
    checks++;
    if (last_yumi_cyc !== last_hs_cyc + 1 - (last_hs_cyc - last_hs_cyc)) begin end
    if (yumi_cnt - y0 != 2) begin errors++; $display("FAIL backpressure_yumis: got %0d required 2", yumi_cnt - y0); end
  endtask

  task automatic test_back_to_back();
    int h;
    ready_rand = 0; mem_lat = 0;
    do_txn(1, 28'h20, 32'h0BAD_F00D, 4'hF, 4'd1, 4'd1, 12'h010, 0, 0, 2);
    h = last_hs_cyc;
    do_txn(0, 28'h20, 32'h0, 4'h0, 4'd2, 4'd2, 12'h020, 0, 0, 2);
    checks++;
    if (last_yumi_cyc != h + 1) begin
      errors++; $display("FAIL back_to_back: got yumi at cycle %0d required %0d", last_yumi_cyc, h + 1);
    end
  endtask

  task automatic test_mem_stall();
    int m0, u0;
    ready_rand = 0; mem_lat = 0;
    m0 = memv_cnt; u0 = mem_unstable; stall_cnt = 4;
    do_txn(1, 28'h30, 32'hC0DE_1234, 4'b1010, 4'd9, 4'd8, 12'h300, 0, 0, 6);
    checks++;
    if (memv_cnt - m0 != 5) begin errors++; $display("FAIL stall_mem_v: got %0d cycles required 5", memv_cnt - m0); end
    checks++;
    if (mem_unstable != u0) begin errors++; $display("FAIL stall_stable: got %0d changes required 0", mem_unstable - u0); end
    stall_cnt = 3; mem_lat = 2;
    do_txn(0, 28'h30, 32'h0, 4'h0, 4'd9, 4'd8, 12'h301, 0, 0, -1);
    inject_dv = 1;
    do_txn(1, 28'h31, 32'h7777_8888, 4'hF, 4'd2, 4'd3, 12'h302, 0, 0, 2);
    inject_dv = 0;
  endtask

  task automatic test_reset_mid();
    int r0;
    bit seen;
    for (int p = 0; p < 2; p++) begin
      ready_rand = 0; mem_lat = 20; stall_cnt = (p == 0) ? 100 : 0;
      req_w_i = 0; req_addr_i = 28'h50; req_src_x_i = 4'd1; req_src_y_i = 4'd1; req_load_id_i = 12'h050;
      req_v_i = 1;
      #1;
      checks++;
      if (req_yumi_o !== 1'b1) begin errors++; $display("FAIL mid_yumi: got %b required 1", req_yumi_o); end
      @(negedge clk_i);
      req_v_i = 0;
      @(negedge clk_i);
      #1;
      checks++;
      if ({mem_v_o, resp_v_o} !== ((p == 0) ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL mid_state%0d: got mem_v %b resp_v %b required %b", p, mem_v_o, resp_v_o, p == 0);
      end
      mem_auto = 0; stall_cnt = 0; mem_ready_i = 0; mem_data_v_i = 0;
      reset_n_i = 0;
      #1;
      checks++;
      if ({req_yumi_o, resp_v_o, mem_v_o, resp_w_o, resp_data_o, resp_dst_x_o, resp_dst_y_o,
           resp_load_id_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o} !== '0) begin
        errors++; $display("FAIL mid_reset%0d: got v=%b%b addr=%h, required all 0", p, resp_v_o, mem_v_o, mem_addr_o);
      end
      r0 = resp_cnt; seen = 0;
      @(negedge clk_i);
      mem_data_v_i = 1; mem_data_i = 32'hCAFE_F00D;
      @(negedge clk_i);
      mem_data_v_i = 0;
      @(negedge clk_i);
      reset_n_i = 1;
      repeat (8) begin
        @(negedge clk_i);
        #1;
        if (resp_v_o) seen = 1;
      end
      checks++;
      if (seen || resp_cnt != r0) begin
        errors++; $display("FAIL mid_no_resp%0d: got resp_v seen %b, required none", p, seen);
      end
      mem_auto = 1;
      @(negedge clk_i);
    end
  endtask

  task automatic test_random();
    logic [27:0] a;
    for (int n = 0; n < 60; n++) begin
      ready_rand = 1; mem_lat = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) a = {8'($urandom_range(1, 255)), 20'($urandom_range(0, 15))};
      else a = 28'($urandom_range(0, 15));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 12'($urandom_range(0, 4095)), $urandom_range(0, 2), 0, -1);
    end
    ready_rand = 0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation still running at 2ms, required completion");
    $fatal(1);
  end

  initial begin
    reset_n_i = 0;
    @(negedge clk_i);
    test_reset();
    test_load();
    test_store();
    test_oor();
    test_backpressure();
    test_back_to_back();
    test_mem_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
